// File: rtl/sprite_slot_shifter_if.sv
// Slot-load handshake bundle for sprite_slot_shifter; load_hflip exists only
// when SPRITE_HFLIP_EN is defined.
interface sprite_slot_shifter_if;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  load_slot;
  logic [9:0]  load_x;
  logic [31:0] load_pattern;
  logic        load_palette;
`ifdef SPRITE_HFLIP_EN
  logic        load_hflip;
`endif

  modport master (
`ifdef SPRITE_HFLIP_EN
    output load_hflip,
`endif
    output load_valid, load_slot, load_x, load_pattern, load_palette,
    input  load_ready
  );

  modport slave (
`ifdef SPRITE_HFLIP_EN
    input  load_hflip,
`endif
    input  load_valid, load_slot, load_x, load_pattern, load_palette,
    output load_ready
  );
endinterface

// File: rtl/sprite_slot_shifter.sv
// Nine-slot sprite line shifter: slots are loaded between lines, then each streams
// 16 two-bit pixels as the raster passes its x. Horizontal flip via SPRITE_HFLIP_EN.
module sprite_slot_shifter (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 line_start,
  input  logic                 pix_en,
  input  logic [9:0]           hcount,
  sprite_slot_shifter_if.slave load_bus,
  output logic [8:0][1:0]      pixel_data_out,
  output logic [8:0]           palette_data_out,
  output logic                 line_done
);
  localparam int         NUM_SLOTS = 9;
  localparam logic [9:0] LAST_COL  = 10'd639;
  localparam logic [9:0] LINE_W    = 10'd640;

  typedef enum logic {LOAD, DISPLAY} top_state_t;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_DONE} slot_state_t;

  top_state_t           top_st;
  slot_state_t          slot_st  [NUM_SLOTS];
  logic [3:0]           slot_idx [NUM_SLOTS];
  logic [9:0]           slot_x   [NUM_SLOTS];
  logic [31:0]          slot_pat [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_pal;
  logic [NUM_SLOTS-1:0] slot_flip;
  logic [NUM_SLOTS-1:0] slot_vld;
  logic [NUM_SLOTS-1:0] load_hit;
  logic                 load_fire;

  // Pixel k counted from the MSB end; a flipped slot walks the pattern backwards.
  function automatic logic [1:0] pix_sel(input logic [31:0] pat, input logic [3:0] idx,
                                         input logic flip);
    logic [3:0]  k;
    logic [31:0] sh;
    k  = flip ? ~idx : idx;
    sh = pat << {k, 1'b0};
    return sh[31:30];
  endfunction

  assign load_bus.load_ready = (top_st == LOAD);
  assign load_fire           = load_bus.load_valid && (top_st == LOAD);

  always_comb begin
    load_hit = '0;
    if (load_fire && (load_bus.load_slot < 4'd9)) load_hit[load_bus.load_slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (load_hit[s]) begin
        slot_x[s]   <= load_bus.load_x;
        slot_pat[s] <= load_bus.load_pattern;
        slot_pal[s] <= load_bus.load_palette;
      end
    end
  end

`ifdef SPRITE_HFLIP_EN
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (load_hit[s]) slot_flip[s] <= load_bus.load_hflip;
    end
  end
`else
  assign slot_flip = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      top_st           <= LOAD;
      slot_vld         <= '0;
      line_done        <= 1'b0;
      pixel_data_out   <= '0;
      palette_data_out <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slot_st[s]  <= S_IDLE;
        slot_idx[s] <= '0;
      end
    end else begin
      line_done <= 1'b0;
      case (top_st)
        LOAD: begin
          slot_vld <= slot_vld | load_hit;
          if (pix_en) begin
            pixel_data_out   <= '0;
            palette_data_out <= '0;
          end
          // A load landing with line_start is armed for this same line.
          if (line_start) begin
            top_st <= DISPLAY;
            for (int s = 0; s < NUM_SLOTS; s++)
              slot_st[s] <= (slot_vld[s] || load_hit[s]) ? S_ARMED : S_IDLE;
          end
        end
        DISPLAY: begin
          if (pix_en) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
              pixel_data_out[s]   <= 2'b00;
              palette_data_out[s] <= 1'b0;
              unique case (slot_st[s])
                S_ARMED: begin
                  if ((hcount == slot_x[s]) && (slot_x[s] < LINE_W)) begin
                    slot_st[s]          <= S_ACTIVE;
                    slot_idx[s]         <= '0;
                    pixel_data_out[s]   <= pix_sel(slot_pat[s], 4'd0, slot_flip[s]);
                    palette_data_out[s] <= slot_pal[s];
                  end
                end
                S_ACTIVE: begin
                  if (slot_idx[s] == 4'd15) begin
                    slot_st[s] <= S_DONE;
                  end else begin
                    slot_idx[s]         <= slot_idx[s] + 4'd1;
                    pixel_data_out[s]   <= pix_sel(slot_pat[s], slot_idx[s] + 4'd1, slot_flip[s]);
                    palette_data_out[s] <= slot_pal[s];
                  end
                end
                default: ;
              endcase
            end
            // Last column: its pixels are still presented, then the line retires.
            if (hcount == LAST_COL) begin
              top_st    <= LOAD;
              line_done <= 1'b1;
              slot_vld  <= '0;
              for (int s = 0; s < NUM_SLOTS; s++) slot_st[s] <= S_IDLE;
            end
          end
        end
        default: top_st <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_slot_shifter.sv
// Randomized bench for sprite_slot_shifter against a column-formula reference model.
module tb_sprite_slot_shifter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            line_start;
  logic            pix_en;
  logic [9:0]      hcount;
  logic [8:0][1:0] pixel_data_out;
  logic [8:0]      palette_data_out;
  logic            line_done;

  sprite_slot_shifter_if load_bus ();

  sprite_slot_shifter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .line_start       (line_start),
    .pix_en           (pix_en),
    .hcount           (hcount),
    .load_bus         (load_bus),
    .pixel_data_out   (pixel_data_out),
    .palette_data_out (palette_data_out),
    .line_done        (line_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what each slot holds and which slots belong to the current line.
  bit              m_vld  [9];
  bit              m_arm  [9];
  int              m_x    [9];
  logic [31:0]     m_pat  [9];
  bit              m_pal  [9];
  bit              m_flip [9];
  bit              m_display;
  logic [8:0][1:0] exp_pix;
  logic [8:0]      exp_pal;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void arm();
    for (int s = 0; s < 9; s++) m_arm[s] = m_vld[s];
    m_display = 1'b1;
  endfunction

  function automatic void line_end();
    for (int s = 0; s < 9; s++) begin
      m_vld[s] = 1'b0;
      m_arm[s] = 1'b0;
    end
    m_display = 1'b0;
  endfunction

  // Sprite at x covers columns x..x+15; column h shows pixel (h - x).
  function automatic void expect_col(int h);
    for (int s = 0; s < 9; s++) begin
      exp_pix[s] = 2'b00;
      exp_pal[s] = 1'b0;
      if (m_arm[s] && (m_x[s] < 640) && (h >= m_x[s]) && (h < m_x[s] + 16)) begin
        int k;
        int sh;
        k  = h - m_x[s];
        sh = m_flip[s] ? 2 * k : 30 - 2 * k;
        exp_pix[s] = 2'((m_pat[s] >> sh) & 32'h3);
        exp_pal[s] = m_pal[s];
      end
    end
  endfunction

  task automatic load(int slot, int x, logic [31:0] pat, bit pal, bit flip, bit with_ls);
    load_bus.load_valid   = 1'b1;
    load_bus.load_slot    = 4'(slot);
    load_bus.load_x       = 10'(x);
    load_bus.load_pattern = pat;
    load_bus.load_palette = pal;
`ifdef SPRITE_HFLIP_EN
    load_bus.load_hflip   = flip;
`endif
    line_start = with_ls;
    check("load_ready_at_load", 32'(load_bus.load_ready), 32'h1);
    tick();
    load_bus.load_valid = 1'b0;
    line_start          = 1'b0;
    if (slot < 9) begin
      m_vld[slot] = 1'b1;
      m_x[slot]   = x;
      m_pat[slot] = pat;
      m_pal[slot] = pal;
`ifdef SPRITE_HFLIP_EN
      m_flip[slot] = flip;
`else
      m_flip[slot] = 1'b0;
`endif
    end
    if (with_ls) begin
      arm();
      check("ready_in_display", 32'(load_bus.load_ready), 32'h0);
    end
  endtask

  task automatic start_line();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    arm();
    check("ready_in_display", 32'(load_bus.load_ready), 32'h0);
  endtask

  task automatic sweep(int from, int to);
    for (int h = from; h <= to; h++) begin
      if ($urandom_range(0, 3) == 0) begin
        pix_en     = 1'b0;
        hcount     = 10'($urandom_range(0, 1023));
        line_start = ($urandom_range(0, 7) == 0);
        tick();
        line_start = 1'b0;
        check($sformatf("hold_pix_c%0d", h), 32'(pixel_data_out), 32'(exp_pix));
        check($sformatf("hold_pal_c%0d", h), 32'(palette_data_out), 32'(exp_pal));
      end
      pix_en = 1'b1;
      hcount = 10'(h);
      tick();
      pix_en = 1'b0;
      expect_col(h);
      check($sformatf("pix_c%0d", h), 32'(pixel_data_out), 32'(exp_pix));
      check($sformatf("pal_c%0d", h), 32'(palette_data_out), 32'(exp_pal));
      check($sformatf("line_done_c%0d", h), 32'(line_done), 32'(h == 639));
      if (h == 639) begin
        check("ready_after_line", 32'(load_bus.load_ready), 32'h1);
        line_end();
      end
    end
    if (to == 639) begin
      tick();
      check("line_done_single", 32'(line_done), 32'h0);
    end
  endtask

  task automatic load_pix_clear();
    pix_en = 1'b1;
    hcount = 10'($urandom_range(0, 1023));
    tick();
    pix_en  = 1'b0;
    exp_pix = '0;
    exp_pal = '0;
    check("load_pix_clear", 32'(pixel_data_out), 32'h0);
    check("load_pal_clear", 32'(palette_data_out), 32'h0);
  endtask

  task automatic random_line();
    int n;
    int last_x;
    n      = $urandom_range(0, 8);
    last_x = $urandom_range(0, 639);
    for (int i = 0; i < n; i++) begin
      int x;
      case ($urandom_range(0, 3))
        0:       x = $urandom_range(0, 1023);
        1:       x = $urandom_range(615, 660);
        2:       x = $urandom_range(0, 639);
        default: x = last_x;
      endcase
      last_x = x;
      load($urandom_range(0, 11), x, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), (i == n - 1) && ($urandom_range(0, 1) == 1));
    end
    if (!m_display) start_line();
    sweep(0, 639);
    load_pix_clear();
  endtask

  initial begin
    logic [8:0][1:0] masked;
    reset_n               = 1'b0;
    line_start            = 1'b0;
    pix_en                = 1'b0;
    hcount                = '0;
    load_bus.load_valid   = 1'b0;
    load_bus.load_slot    = '0;
    load_bus.load_x       = '0;
    load_bus.load_pattern = '0;
    load_bus.load_palette = 1'b0;
`ifdef SPRITE_HFLIP_EN
    load_bus.load_hflip   = 1'b0;
`endif
    for (int s = 0; s < 9; s++) begin
      m_vld[s] = 1'b0; m_arm[s] = 1'b0; m_x[s] = 0;
      m_pat[s] = '0;   m_pal[s] = 1'b0; m_flip[s] = 1'b0;
    end
    m_display = 1'b0;
    exp_pix   = '0;
    exp_pal   = '0;

    tick();
    tick();
    check("rst_pix", 32'(pixel_data_out), 32'h0);
    check("rst_pal", 32'(palette_data_out), 32'h0);
    check("rst_line_done", 32'(line_done), 32'h0);
    check("rst_ready", 32'(load_bus.load_ready), 32'h1);
    reset_n = 1'b1;
    tick();

    // Single sprite: 01 at its first column, 11 at its last.
    load(3, 100, 32'h4000_0003, 1'b1, 1'b0, 1'b0);
    start_line();
    sweep(0, 100);
    check("s3_c100", 32'(pixel_data_out[3]), 32'h1);
    masked = pixel_data_out;
    masked[3] = 2'b00;
    check("others_c100", 32'(masked), 32'h0);
    sweep(101, 115);
    check("s3_c115", 32'(pixel_data_out[3]), 32'h3);
    sweep(116, 639);
    load_pix_clear();

    // Two slots sharing x, second load concurrent with line_start.
    load(0, 200, 32'h1B1B_E4E4, 1'b0, 1'b0, 1'b0);
    load(8, 200, 32'hE4E4_1B1B, 1'b1, 1'b0, 1'b1);
    sweep(0, 639);

    // Out-of-range slot number is swallowed.
    load(12, 50, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    start_line();
    sweep(0, 639);

    // Right-edge truncation, then an empty line.
    load(1, 630, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    start_line();
    sweep(0, 639);
    load_pix_clear();
    start_line();
    sweep(0, 639);

    // Reset in the middle of an active sprite.
    load(2, 200, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    start_line();
    sweep(0, 205);
    check("s2_c205", 32'(pixel_data_out[2]), 32'h3);
    reset_n = 1'b0;
    pix_en  = 1'b1;
    hcount  = 10'd206;
    tick();
    reset_n = 1'b1;
    pix_en  = 1'b0;
    line_end();
    exp_pix = '0;
    exp_pal = '0;
    check("midrst_pix", 32'(pixel_data_out), 32'h0);
    check("midrst_pal", 32'(palette_data_out), 32'h0);
    check("midrst_line_done", 32'(line_done), 32'h0);
    check("midrst_ready", 32'(load_bus.load_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_done", 32'(line_done), 32'h0);
    end
    start_line();
    sweep(0, 639);

`ifdef SPRITE_HFLIP_EN
    load(5, 0, 32'h4000_0003, 1'b1, 1'b1, 1'b0);
    start_line();
    sweep(0, 0);
    check("flip_c0", 32'(pixel_data_out[5]), 32'h3);
    sweep(1, 15);
    check("flip_c15", 32'(pixel_data_out[5]), 32'h1);
    sweep(16, 639);
`endif

    for (int i = 0; i < 10; i++) random_line();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
